// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - four-digit BCD to 14-bit binary converter (reverse double-dabble)
//
// Optional feature macro: BCD_TO_BIN_DIGIT_CHK_EN (invalid-digit detection)
//
// Ports:
//   clk     in   1   clock, rising edge
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   conversion request, sampled only in IDLE
//   hun     in   4   BCD thousands digit (most significant)
//   ten     in   4   BCD hundreds digit
//   one     in   4   BCD tens digit
//   dot     in   4   BCD units digit (least significant)
//   busy    out  1   high in SHIFT and DONE
//   done    out  1   one-cycle result-valid pulse
//   binary  out  14  converted value, held until the next done
//   err     out  1   invalid-digit flag (tied 0 without the macro)

module bcd_to_bin (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  hun,
  input  logic [3:0]  ten,
  input  logic [3:0]  one,
  input  logic [3:0]  dot,
  output logic        busy,
  output logic        done,
  output logic [13:0] binary,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] bin_q, bin_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [13:0] binary_q, binary_d;

  logic [15:0] bcd_sh, bin_sh, bcd_adj;

  // One reverse double-dabble step: the BCD register's LSB moves into the
  // binary register's MSB, then any nibble that now reads 8..15 held a
  // carried-in half-ten and is corrected by subtracting 3.
  always_comb begin
    bcd_sh  = {1'b0, bcd_q[15:1]};
    bin_sh  = {bcd_q[0], bin_q[15:1]};
    bcd_adj = bcd_sh;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8)
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

`ifdef BCD_TO_BIN_DIGIT_CHK_EN
  logic err_q, err_d;
  logic digit_bad;

  assign digit_bad = (hun > 4'd9) || (ten > 4'd9) || (one > 4'd9) || (dot > 4'd9);
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
`ifdef BCD_TO_BIN_DIGIT_CHK_EN
    err_d    = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {hun, ten, one, dot};
          bin_d   = 16'd0;
          cnt_d   = 5'd0;
          state_d = SHIFT;
`ifdef BCD_TO_BIN_DIGIT_CHK_EN
          if (digit_bad) begin
            binary_d = 14'd0;
            err_d    = 1'b1;
            state_d  = DONE;
          end
`endif
        end
      end

      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_sh;
        cnt_d = cnt_q + 5'd1;
        // cnt_q counts completed steps; 15 means this edge performs the 16th.
        if (cnt_q == 5'd15) begin
          binary_d = bin_sh[13:0];
`ifdef BCD_TO_BIN_DIGIT_CHK_EN
          err_d    = 1'b0;
`endif
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bcd_q    <= 16'd0;
      bin_q    <= 16'd0;
      cnt_q    <= 5'd0;
      binary_q <= 14'd0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
    end
  end

`ifdef BCD_TO_BIN_DIGIT_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign binary = binary_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed self-checking bench for bcd_to_bin

module tb_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  hun, ten, one, dot;
  logic        busy, done, err;
  logic [13:0] binary;

  int total;
  int bad;

  bcd_to_bin dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .hun    (hun),
    .ten    (ten),
    .one    (one),
    .dot    (dot),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one conversion from IDLE and check latency, result and pulse width.
  task automatic convert(input string tag, input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0,
                         input int exp_lat, input int exp_bin, input int exp_err,
                         input bit check_bin);
    int lat;
    hun = d3; ten = d2; one = d1; dot = d0;
    start = 1'b1;
    tick();
    start = 1'b0;
    hun = 4'($urandom); ten = 4'($urandom); one = 4'($urandom); dot = 4'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    if (check_bin) chk({tag, "_binary"}, int'(binary), exp_bin);
    chk({tag, "_err"}, int'(err), exp_err);
    chk({tag, "_busy_at_done"}, int'(busy), 1);
    tick();
    chk({tag, "_done_one_cycle"}, int'(done), 0);
    chk({tag, "_idle_after"}, int'(busy), 0);
    if (check_bin) chk({tag, "_binary_hold"}, int'(binary), exp_bin);
  endtask

  initial begin
    int n;
    int dones;
    int busy_low;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    hun = 4'd0; ten = 4'd0; one = 4'd0; dot = 4'd0;

    // Reset state
    #12;
    chk("rst_busy",   int'(busy),   0);
    chk("rst_done",   int'(done),   0);
    chk("rst_binary", int'(binary), 0);
    chk("rst_err",    int'(err),    0);
    tick();
    rst_n = 1'b1;
    tick();

    // Main function
    convert("c9999", 4'd9, 4'd9, 4'd9, 4'd9, 17, 9999, 0, 1'b1);
    convert("c0000", 4'd0, 4'd0, 4'd0, 4'd0, 17, 0,    0, 1'b1);
    convert("c4095", 4'd4, 4'd0, 4'd9, 4'd5, 17, 4095, 0, 1'b1);
    convert("c1234", 4'd1, 4'd2, 4'd3, 4'd4, 17, 1234, 0, 1'b1);
    convert("c0508", 4'd0, 4'd5, 4'd0, 4'd8, 17, 508,  0, 1'b1);

    // start pulses while busy are ignored
    hun = 4'd1; ten = 4'd2; one = 4'd3; dot = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    busy_low = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c <= 17 && !busy) busy_low++;
      if (done) dones++;
      if (c == 17) chk("ign_binary", int'(binary), 1234);
      start = (c == 3 || c == 10) ? 1'b1 : 1'b0;
      if (c == 3) begin hun = 4'd9; ten = 4'd9; one = 4'd9; dot = 4'd9; end
      tick();
    end
    start = 1'b0;
    chk("ign_done_count", dones, 1);
    chk("ign_busy_low_cycles", busy_low, 0);
    chk("ign_binary_hold", int'(binary), 1234);

    // Reset in the middle of SHIFT aborts the conversion
    hun = 4'd8; ten = 4'd7; one = 4'd6; dot = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   int'(busy),   0);
    chk("mid_rst_done",   int'(done),   0);
    chk("mid_rst_binary", int'(binary), 0);
    chk("mid_rst_err",    int'(err),    0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) dones++;
      tick();
    end
    chk("mid_rst_no_activity", dones, 0);
    convert("c0042", 4'd0, 4'd0, 4'd4, 4'd2, 17, 42, 0, 1'b1);

    // Invalid digit
`ifdef BCD_TO_BIN_DIGIT_CHK_EN
    convert("bad_digit", 4'd1, 4'd10, 4'd0, 4'd0, 1, 0, 1, 1'b1);
    convert("after_bad", 4'd0, 4'd0, 4'd0, 4'd9, 17, 9, 0, 1'b1);
`else
    convert("bad_digit", 4'd1, 4'd10, 4'd0, 4'd0, 17, 0, 0, 1'b0);
`endif

    // start held high: results every 18 cycles
    hun = 4'd0; ten = 4'd0; one = 4'd0; dot = 4'd7;
    start = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_first_latency", n, 17);
    chk("b2b_first_binary", int'(binary), 7);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 40);
      chk("b2b_period", n, 18);
      chk("b2b_binary", int'(binary), 7);
    end
    start = 1'b0;
    tick();
    tick();
    chk("b2b_idle_after", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
